// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: latches request edges, prioritises against IE/INM and
// the in-service level, then walks flush -> EPC save -> PC redirect and retires levels on eret.
module int_sequencer #(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int unsigned VEC_SHIFT = 4
) (
    input  logic        in_clk,
    input  logic        in_RST,
    input  logic [2:0]  in_req,
    input  logic        in_IE,
    input  logic [3:0]  in_INM,
    input  logic        in_wb_valid,
    input  logic        in_stall,
    input  logic        in_eret,
    output logic        out_BK,
    output logic        out_NIE,
    output logic [1:0]  out_code,
    output logic        out_redirect,
    output logic [31:0] out_vector,
    output logic [2:0]  out_pending,
    output logic [2:0]  out_ISR,
    output logic        out_busy
);

    localparam int unsigned NSRC = 3;
    localparam int unsigned SW   = 3;

    localparam logic [SW-1:0] IDLE     = 3'd0;
    localparam logic [SW-1:0] FLUSH    = 3'd1;
    localparam logic [SW-1:0] SAVE     = 3'd2;
    localparam logic [SW-1:0] REDIRECT = 3'd3;
    localparam logic [SW-1:0] SERVICE  = 3'd4;

    logic [SW-1:0]   state_q, state_d;
    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] isr_q, isr_d;
    logic [1:0]      sel_q, sel_d;
    logic            run_q;

    logic [NSRC-1:0] edge_c;
    logic [NSRC-1:0] eligible_c;
    logic [NSRC-1:0] pending_clr_c;
    logic            unused_inm;

    // Mask bit 3 has no source behind it.
    assign unused_inm = in_INM[3];

    // Sources strictly above the highest in-service level.
    function automatic logic [NSRC-1:0] above_mask(input logic [NSRC-1:0] isr);
        if (isr[2])      return 3'b000;
        else if (isr[1]) return 3'b100;
        else if (isr[0]) return 3'b110;
        else             return 3'b111;
    endfunction

    function automatic logic [NSRC-1:0] top_onehot(input logic [NSRC-1:0] v);
        if (v[2])      return 3'b100;
        else if (v[1]) return 3'b010;
        else if (v[0]) return 3'b001;
        else           return 3'b000;
    endfunction

    function automatic logic [1:0] top_idx(input logic [NSRC-1:0] v);
        if (v[2])      return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // run_q holds off edge detection until req_q has sampled the pins once after reset.
    assign edge_c     = run_q ? (in_req & ~req_q) : 3'b000;
    assign eligible_c = pending_q & ~in_INM[2:0] & above_mask(isr_q);

    // Next-state and bookkeeping.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        isr_d         = isr_q;
        pending_clr_c = 3'b000;
        case (state_q)
            IDLE: begin
                if (in_IE && (eligible_c != 3'b000) && !in_eret) begin
                    state_d = FLUSH;
                    sel_d   = top_idx(eligible_c);
                end
            end
            FLUSH: begin
                if (!in_stall && in_wb_valid) state_d = SAVE;
            end
            SAVE: begin
                pending_clr_c = 3'b001 << sel_q;
                isr_d         = isr_q | (3'b001 << sel_q);
                state_d       = REDIRECT;
            end
            REDIRECT: begin
                if (!in_stall) state_d = SERVICE;
            end
            SERVICE: begin
                if (in_eret) begin
                    isr_d = isr_q & ~top_onehot(isr_q);
                    if (isr_d == 3'b000) state_d = IDLE;
                end else if (in_IE && (eligible_c != 3'b000)) begin
                    state_d = FLUSH;
                    sel_d   = top_idx(eligible_c);
                end
            end
            default: state_d = IDLE;
        endcase
        // A new edge on the same cycle as the SAVE clear keeps the request pending.
        pending_d = (pending_q & ~pending_clr_c) | edge_c;
    end

    // State, bookkeeping and outputs; outputs are decoded from the next state so they
    // line up with the state register.
    always_ff @(posedge in_clk or negedge in_RST) begin
        if (!in_RST) begin
            state_q      <= IDLE;
            req_q        <= 3'b000;
            pending_q    <= 3'b000;
            isr_q        <= 3'b000;
            sel_q        <= 2'd0;
            run_q        <= 1'b0;
            out_BK       <= 1'b0;
            out_NIE      <= 1'b0;
            out_code     <= 2'd0;
            out_redirect <= 1'b0;
            out_vector   <= 32'h0;
            out_pending  <= 3'b000;
            out_ISR      <= 3'b000;
            out_busy     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= in_req;
            pending_q    <= pending_d;
            isr_q        <= isr_d;
            sel_q        <= sel_d;
            run_q        <= 1'b1;
            out_BK       <= (state_d == FLUSH);
            out_NIE      <= (state_d == SAVE);
            out_code     <= (state_d == IDLE) ? 2'd0 : sel_d;
            out_redirect <= (state_d == REDIRECT);
            out_vector   <= (state_d == REDIRECT) ? (VEC_BASE + (32'(sel_d) << VEC_SHIFT)) : 32'h0;
            out_pending  <= pending_d;
            out_ISR      <= isr_d;
            out_busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Interrupt entry/exit sequencer for the CP0 side of the register file. It latches three external interrupt requests, prioritises and masks them against the CP0 IE/INM state, and sequences entry: flush the pipeline, save the EPC, clear IE, then redirect the PC to a per-source vector. It tracks in-service levels so higher-priority sources can pre-empt a running handler, and retires levels on eret. It sits between the interrupt pins, the CP0 register block (driving its BK/NIE/code inputs) and the PC redirect mux.

## Interface
- VEC_BASE, 32'h0000_0100, handler vector base address
- VEC_SHIFT, 4, log2 of vector stride; vector = VEC_BASE + (code << VEC_SHIFT)
- in_clk  in  1  system clock, all state updates on rising edge
- in_RST  in  1  reset, asynchronous, active-low
- in_req  in  3  raw interrupt request lines; rising edge = one request; bit 2 highest priority
- in_IE  in  1  CP0 global interrupt enable
- in_INM  in  4  CP0 interrupt mask; bit i = 1 masks source i (bit 3 unused)
- in_wb_valid  in  1  WB stage holds a valid instruction whose PC may be saved as EPC
- in_stall  in  1  pipeline cannot accept a flush completion or redirect this cycle
- in_eret  in  1  eret retiring this cycle
- out_BK  out  1  pipeline flush/break request (drives CP0 in_BK)
- out_NIE  out  1  one-cycle pulse: save EPC and clear IE (drives CP0 in_NIE)
- out_code  out  2  code of the source being entered (drives CP0 in_code)
- out_redirect  out  1  PC redirect strobe
- out_vector  out  32  redirect target
- out_pending  out  3  latched, not-yet-entered requests
- out_ISR  out  3  in-service bits
- out_busy  out  1  state != IDLE

## Operation
- Edge detect: req_q registers in_req; an edge on bit i is in_req[i] & ~req_q[i]. An edge sets pending[i] on the next clock.
- Current level: index of the highest set ISR bit; none if ISR = 0.
- Eligible: pending & ~in_INM[2:0], restricted to sources strictly above the current level. Selection is the highest eligible index.
- States: IDLE, FLUSH, SAVE, REDIRECT, SERVICE.
- IDLE -> FLUSH when in_IE, eligible != 0, and !in_eret. The selected code latches into sel_q at that transition and is held until SAVE.
- FLUSH:
  - out_BK = 1.
  - Stays in FLUSH while in_stall or !in_wb_valid; otherwise -> SAVE.
- SAVE (exactly 1 cycle):
  - out_NIE = 1, out_code = sel_q.
  - On exit, pending[sel_q] is cleared and ISR[sel_q] is set; -> REDIRECT.
- REDIRECT:
  - out_redirect = 1, out_vector = VEC_BASE + (sel_q << VEC_SHIFT).
  - Stays in REDIRECT while in_stall; otherwise -> SERVICE.
- SERVICE:
  - If in_eret: clear the highest set ISR bit. If ISR becomes 0 -> IDLE, else stay in SERVICE.
  - Else if in_IE and eligible != 0 (pre-emption): latch sel_q and -> FLUSH.
  - in_eret has priority over pre-emption in the same cycle.
- out_code = sel_q in every state except IDLE, where it is 0.
- out_vector = 0 whenever out_redirect = 0.
- Pending set/clear collision: if a new edge on source i arrives in the cycle pending[i] is cleared by SAVE, set wins and pending[i] stays 1.
- Masking changes while in FLUSH do not cancel entry; sel_q is committed.
- in_eret in IDLE or FLUSH is ignored for ISR (ISR is unchanged).

## Timing
- Reset (in_RST low, asynchronous): state = IDLE; pending, ISR, req_q and sel_q = 0; all outputs 0.
- Reset deassertion is sampled synchronously; the first edge detect occurs on the 2nd clock after release.
- Minimum latency, from in_req rising before clock edge 0 to out_redirect high: 4 cycles.
  - edge 0: pending set
  - edge 1: FLUSH
  - edge 2: SAVE
  - edge 3: REDIRECT, out_redirect visible in the following cycle
- Each cycle of in_stall or !in_wb_valid adds one cycle in FLUSH; each cycle of in_stall adds one cycle in REDIRECT.
- out_NIE is high for exactly one cycle per entry. out_BK is high for every FLUSH cycle, minimum 1.
- ISR update on eret is visible the cycle after in_eret.
- Reset asserted mid-sequence, in any state, returns to IDLE immediately with no NIE or redirect pulse.

## Test plan
- Single request: hold in_IE = 1, in_INM = 0, in_wb_valid = 1, in_stall = 0; pulse in_req[0]. Required: out_BK is 1 for 1 cycle, then out_NIE is 1 with out_code = 0, then out_redirect is 1 with out_vector = 32'h100 and ISR = 001. After in_eret, ISR = 000 and state returns to IDLE.
- Priority: raise in_req[0] and in_req[2] in the same cycle. Required: source 2 is entered first (out_vector = 32'h120) and out_pending = 001. After eret, source 0 is entered (out_vector = 32'h100).
- Pre-emption: while in SERVICE with ISR = 001, pulse in_req[1] with in_IE = 1. Required: FLUSH/SAVE sequence with out_code = 1, ISR = 011, out_vector = 32'h110. First eret gives ISR = 001; second eret gives ISR = 000.
- Masking and IE: with in_INM = 0001, pulse in_req[0]. Required: pending = 001 and state stays IDLE. Clear in_INM; with in_IE = 0 the state still stays IDLE. Set in_IE = 1; entry occurs.
- Stalls: hold in_wb_valid = 0 for 3 cycles in FLUSH and in_stall = 1 for 2 cycles in REDIRECT. Required: out_BK is high for 4 cycles, out_NIE is high for exactly 1 cycle, and out_redirect is held for 3 cycles with a stable out_vector.
- Reset mid-entry: assert in_RST low during SAVE. Required: all outputs drop to 0 asynchronously, and pending = ISR = 0 after release.
